ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
- Multi-cycle controller for block transfers between the 16x32 register file and data memory: LDM/STM and PUSH/POP.
- Walks a 16-bit register list in ascending order and drives the register file's read address (rt), write address (rd) and write enable.
- Issues one word request per listed register on a req/gnt/rvalid memory port.
- Performs optional base writeback.
- Sits between decode and the register file; the pipeline stalls while o_busy=1.

Parameters:
- WORD_BYTES, 4, address step per transferred register
- LIST_W, 16, register list width (one bit per architectural register)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  launch transfer; sampled only in IDLE
- i_load  in  1  1=LDM (memory->regs), 0=STM (regs->memory)
- i_reg_list  in  16  bit n set = transfer register n
- i_base  in  32  current base register value
- i_base_reg  in  4  base register index, used for writeback
- i_incr  in  1  1=increment, 0=decrement
- i_before  in  1  1=pre-index, 0=post-index
- i_wback  in  1  write final base back to i_base_reg
- o_busy  out  1  high from the cycle after accepted start until DONE inclusive
- o_done  out  1  one-cycle pulse in DONE
- o_addr_rt  out  4  register file read address (store data)
- i_rt_r  in  32  register file registered read data; valid 1 cycle after o_addr_rt
- o_addr_rd  out  4  register file write address
- o_rd  out  32  register file write data
- o_rd_wr_en  out  1  register file write enable
- o_pc_wr_en  out  1  PC load request (register 15 loaded)
- o_pc_val  out  32  PC load value
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1=write
- o_mem_addr  out  32  word address, bits[1:0]=0
- o_mem_wdata  out  32  store data
- i_mem_gnt  in  1  request accepted this cycle
- i_mem_rvalid  in  1  load data valid
- i_mem_rdata  in  32  load data

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0; internal list, count and address cleared.
- Reset mid-operation aborts immediately; no further register or memory writes occur.
- States: IDLE, CALC, RD, REQ, WAIT, WR, WB, DONE.
- IDLE: on i_start, latch all i_* controls -> CALC. i_start while not IDLE is ignored.
- CALC (1 cycle):
  - N = popcount(list).
  - Start address (32-bit, modulo 2^32): IA = base; IB = base+4; DA = base-4N+4; DB = base-4N.
  - Final base = base+4N if incr, else base-4N.
  - N=0 -> DONE: no memory access, no writeback.
  - Otherwise -> RD for store, REQ for load.
- Current register = lowest set bit of the remaining list.
- RD (store only, 1 cycle): o_addr_rt = current register -> REQ.
- REQ:
  - o_mem_req=1, o_mem_addr = current address, o_mem_we = ~load.
  - Store: o_mem_wdata = i_rt_r, captured on RD exit and held stable.
  - Address, we and wdata stay stable until i_mem_gnt.
  - On gnt: clear the current list bit and add 4 to the address. Store goes to RD (more bits remain) or WB (none remain). Load goes to WAIT.
- WAIT: hold until i_mem_rvalid, capture i_mem_rdata -> WR.
- WR (1 cycle):
  - Register 0-14: o_rd_wr_en=1, o_addr_rd = register, o_rd = data.
  - Register 15: o_pc_wr_en=1, o_pc_val = data with bits[1:0] cleared. o_rd_wr_en stays 0, because the register file overwrites the PC slot every cycle.
  - -> RD/REQ if bits remain, else WB.
- WB (1 cycle): if wback and not (load with base_reg in list): o_rd_wr_en=1, o_addr_rd = base_reg, o_rd = final base. Otherwise no write. -> DONE.
- DONE: o_done=1 -> IDLE. A new i_start is accepted in the following IDLE cycle.
- Timing:
  - Store, zero-wait memory: 2 cycles per register.
  - Load, gnt and rvalid each one cycle after request: 3 cycles per register.
- Only one outstanding memory request at any time.
- o_rd_wr_en and o_pc_wr_en are never high in the same cycle.
- All outputs are registered.

Test Plan:
- STM IA: base=0x1000, list=0x000A (r1,r3), wback=1, gnt always 1 -> writes at 0x1000 (r1 data), 0x1004 (r3 data); WB writes 0x1008 to base_reg; o_done once.
- LDM DB: base=0x2000, list=0x8003 (r0,r1,r15) -> reads 0x1FF4, 0x1FF8, 0x1FFC; r0/r1 via o_rd_wr_en; PC via o_pc_wr_en with value&~3; writeback base=0x1FF4.
- Load with base in list: base_reg=2, list=0x0004, wback=1 -> r2 gets loaded data; no WB write.
- Empty list -> o_busy for CALC and DONE only; no o_mem_req; no register writes.
- Memory stall: gnt low for 5 cycles, rvalid delayed 3 cycles -> o_mem_addr stable throughout; exactly one write per register; i_start pulses while busy ignored.
- Async reset asserted during WAIT -> all outputs 0 immediately; no subsequent writes; a fresh i_start after release runs correctly.

Source files
------------

// File: rtl/ldm_stm_sequencer_if.sv
// Memory port of the LDM/STM sequencer: req/gnt address phase, rvalid load data.
// Latency: gnt may arrive in the request cycle; rvalid any cycle after gnt.
// Backpressure: memory stalls by holding gnt low; requester keeps req/addr/we/wdata stable.
//
// Signals: o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata are driven by the master (sequencer);
// i_mem_gnt/i_mem_rvalid/i_mem_rdata are driven by the slave (memory).
interface ldm_stm_sequencer_if;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM/PUSH/POP block-transfer sequencer between decode, register file and data memory.
// Latency: 2 cycles per stored register, 3 per loaded register (zero-wait memory), plus CALC/WB/DONE.
// Backpressure: holds the request stable until i_mem_gnt and waits in WAIT for i_mem_rvalid; decode stalls on o_busy.
//
// Ports: clk/rst (async active-low); i_start + latched transfer controls (i_load, i_reg_list,
// i_base, i_base_reg, i_incr, i_before, i_wback); o_busy/o_done status; register file read
// (o_addr_rt -> i_rt_r one cycle later), register file write (o_addr_rd/o_rd/o_rd_wr_en),
// PC load (o_pc_wr_en/o_pc_val); memory port via the mem interface (master side).
module ldm_stm_sequencer #(
  parameter int WORD_BYTES = 4,
  parameter int LIST_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic                       i_load,
  input  logic [LIST_W-1:0]          i_reg_list,
  input  logic [31:0]                i_base,
  input  logic [$clog2(LIST_W)-1:0]  i_base_reg,
  input  logic                       i_incr,
  input  logic                       i_before,
  input  logic                       i_wback,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(LIST_W)-1:0]  o_addr_rt,
  input  logic [31:0]                i_rt_r,
  output logic [$clog2(LIST_W)-1:0]  o_addr_rd,
  output logic [31:0]                o_rd,
  output logic                       o_rd_wr_en,
  output logic                       o_pc_wr_en,
  output logic [31:0]                o_pc_val,
  ldm_stm_sequencer_if.master        mem
);
  localparam int IDX_W = $clog2(LIST_W);
  localparam int CNT_W = $clog2(LIST_W + 1);
  localparam logic [31:0]      STEP   = 32'(WORD_BYTES);
  localparam logic [31:0]      ALIGN  = ~(STEP - 32'd1);
  localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(LIST_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_RD, S_REQ, S_WAIT, S_WR, S_WB, S_DONE} state_t;

  // Index of the lowest set bit (0 when empty).
  function automatic logic [IDX_W-1:0] first_set(input logic [LIST_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LIST_W; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Latched transfer controls
  state_t             state_q, state_d;
  logic               load_q, incr_q, before_q, wback_q, base_in_list_q;
  logic [31:0]        base_q;
  logic [IDX_W-1:0]   base_reg_q;
  // Walk state
  logic [LIST_W-1:0]  list_q, list_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        final_q, final_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  // Registered outputs
  logic               busy_d, done_d, rd_wr_en_d, pc_wr_en_d, mem_req_d, mem_we_d;
  logic [IDX_W-1:0]   addr_rt_d, addr_rd_d;
  logic [31:0]        rd_d, pc_val_d, mem_addr_d, mem_wdata_d;
  logic               mem_req_q, mem_we_q;
  logic [31:0]        mem_addr_q, mem_wdata_q;
  // Combinational helpers
  logic [IDX_W-1:0]   cur_idx;
  logic [LIST_W-1:0]  rest;
  logic [CNT_W-1:0]   n_regs;
  logic [31:0]        span, start_addr;

  always_comb begin
    state_d     = state_q;
    list_d      = list_q;
    addr_d      = addr_q;
    final_d     = final_q;
    cur_d       = cur_q;
    addr_rt_d   = o_addr_rt;
    addr_rd_d   = o_addr_rd;
    rd_d        = o_rd;
    pc_val_d    = o_pc_val;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    rd_wr_en_d  = 1'b0;
    pc_wr_en_d  = 1'b0;
    mem_req_d   = 1'b0;

    cur_idx = first_set(list_q);
    rest    = list_q & ~(LIST_W'(1) << cur_idx);
    n_regs  = popcount(list_q);
    span    = 32'(n_regs) * STEP;
    case ({incr_q, before_q})
      2'b10:   start_addr = base_q;                // increment after
      2'b11:   start_addr = base_q + STEP;         // increment before
      2'b00:   start_addr = base_q - span + STEP;  // decrement after
      default: start_addr = base_q - span;         // decrement before
    endcase

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_CALC;
          list_d    = i_reg_list;
          // The register file read is registered, so the read address runs one
          // cycle ahead of RD: the first register is presented during CALC.
          addr_rt_d = first_set(i_reg_list);
        end
      end
      S_CALC: begin
        addr_d  = start_addr;
        final_d = incr_q ? (base_q + span) : (base_q - span);
        if (n_regs == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (load_q) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = start_addr & ALIGN;
        end else begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        state_d     = S_REQ;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q & ALIGN;
        mem_wdata_d = i_rt_r;
        // Current data is captured; start reading the next register now so it
        // is ready when RD comes round again.
        addr_rt_d   = first_set(rest);
      end
      S_REQ: begin
        if (mem.i_mem_gnt) begin
          list_d = rest;
          addr_d = addr_q + STEP;
          cur_d  = cur_idx;
          if (load_q)            state_d = S_WAIT;
          else if (rest != '0)   state_d = S_RD;
          else                   state_d = S_WB;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem.i_mem_rvalid) begin
          state_d = S_WR;
          // The register file rewrites the PC slot every cycle, so r15 goes
          // through the PC load path instead of the normal write port.
          if (cur_q == PC_IDX) begin
            pc_wr_en_d = 1'b1;
            pc_val_d   = mem.i_mem_rdata & ~32'h3;
          end else begin
            rd_wr_en_d = 1'b1;
            addr_rd_d  = cur_q;
            rd_d       = mem.i_mem_rdata;
          end
        end
      end
      S_WR: begin
        if (list_q != '0) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q & ALIGN;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: begin  // S_DONE
        state_d = S_IDLE;
      end
    endcase

    // Writeback is suppressed when a load also targets the base register:
    // the loaded value wins.
    if (state_d == S_WB) begin
      rd_wr_en_d = wback_q & ~(load_q & base_in_list_q);
      addr_rd_d  = base_reg_q;
      rd_d       = final_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      load_q         <= 1'b0;
      incr_q         <= 1'b0;
      before_q       <= 1'b0;
      wback_q        <= 1'b0;
      base_in_list_q <= 1'b0;
      base_q         <= '0;
      base_reg_q     <= '0;
      list_q         <= '0;
      addr_q         <= '0;
      final_q        <= '0;
      cur_q          <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_addr_rt      <= '0;
      o_addr_rd      <= '0;
      o_rd           <= '0;
      o_rd_wr_en     <= 1'b0;
      o_pc_wr_en     <= 1'b0;
      o_pc_val       <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      list_q      <= list_d;
      addr_q      <= addr_d;
      final_q     <= final_d;
      cur_q       <= cur_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
      o_addr_rt   <= addr_rt_d;
      o_addr_rd   <= addr_rd_d;
      o_rd        <= rd_d;
      o_rd_wr_en  <= rd_wr_en_d;
      o_pc_wr_en  <= pc_wr_en_d;
      o_pc_val    <= pc_val_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (state_q == S_IDLE && i_start) begin
        load_q         <= i_load;
        incr_q         <= i_incr;
        before_q       <= i_before;
        wback_q        <= i_wback;
        base_q         <= i_base;
        base_reg_q     <= i_base_reg;
        base_in_list_q <= i_reg_list[i_base_reg];
      end
    end
  end

  assign mem.o_mem_req   = mem_req_q;
  assign mem.o_mem_we    = mem_we_q;
  assign mem.o_mem_addr  = mem_addr_q;
  assign mem.o_mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with a register-file read model and a
// req/gnt/rvalid memory model whose grant and read-data delays are programmable.
module tb_ldm_stm_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_start, i_load, i_incr, i_before, i_wback;
  logic [15:0] i_reg_list;
  logic [31:0] i_base;
  logic [3:0]  i_base_reg;
  logic        o_busy, o_done, o_rd_wr_en, o_pc_wr_en;
  logic [3:0]  o_addr_rt, o_addr_rd;
  logic [31:0] o_rd, o_pc_val, i_rt_r;

  ldm_stm_sequencer_if mem_bus();

  ldm_stm_sequencer dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_load(i_load), .i_reg_list(i_reg_list),
    .i_base(i_base), .i_base_reg(i_base_reg), .i_incr(i_incr), .i_before(i_before),
    .i_wback(i_wback), .o_busy(o_busy), .o_done(o_done), .o_addr_rt(o_addr_rt),
    .i_rt_r(i_rt_r), .o_addr_rd(o_addr_rd), .o_rd(o_rd), .o_rd_wr_en(o_rd_wr_en),
    .o_pc_wr_en(o_pc_wr_en), .o_pc_val(o_pc_val), .mem(mem_bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Register file: r[n] = 0xC0DE_0000 + n, registered read.
  always @(posedge clk) i_rt_r <= 32'hC0DE_0000 + 32'(o_addr_rt);

  function automatic logic [31:0] ld_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  // Memory model, driven on the falling edge.
  int          gnt_delay = 0, rvalid_delay = 0, req_cnt = 0, rv_cnt = 0;
  int          stable_err = 0, proto_err = 0;
  logic        pending = 1'b0, in_req = 1'b0, h_we;
  logic [31:0] pend_addr, h_addr, h_wdata;
  logic [31:0] st_addr[$], st_data[$], ld_addr[$];

  always @(negedge clk) begin
    mem_bus.i_mem_gnt    = 1'b0;
    mem_bus.i_mem_rvalid = 1'b0;
    if (!rst) begin
      pending = 1'b0; in_req = 1'b0; req_cnt = 0; rv_cnt = 0;
    end else begin
      if (mem_bus.o_mem_req && pending) proto_err++;
      if (pending) begin
        if (rv_cnt >= rvalid_delay) begin
          mem_bus.i_mem_rvalid = 1'b1;
          mem_bus.i_mem_rdata  = ld_word(pend_addr);
          pending = 1'b0;
        end else rv_cnt++;
      end
      if (mem_bus.o_mem_req) begin
        if (mem_bus.o_mem_addr[1:0] != 2'b00) proto_err++;
        if (in_req && (mem_bus.o_mem_addr != h_addr || mem_bus.o_mem_we != h_we ||
                       (h_we && mem_bus.o_mem_wdata != h_wdata))) stable_err++;
        in_req  = 1'b1;
        h_addr  = mem_bus.o_mem_addr;
        h_we    = mem_bus.o_mem_we;
        h_wdata = mem_bus.o_mem_wdata;
        if (req_cnt >= gnt_delay) begin
          mem_bus.i_mem_gnt = 1'b1;
          req_cnt = 0;
          in_req  = 1'b0;
          if (mem_bus.o_mem_we) begin
            st_addr.push_back(mem_bus.o_mem_addr);
            st_data.push_back(mem_bus.o_mem_wdata);
          end else begin
            ld_addr.push_back(mem_bus.o_mem_addr);
            pending = 1'b1; rv_cnt = 0; pend_addr = mem_bus.o_mem_addr;
          end
        end else req_cnt++;
      end
    end
  end

  // Output monitor, sampled just after the rising edge.
  int          done_cnt = 0, busy_cnt = 0, done0 = 0, busy0 = 0;
  logic [31:0] wr_idx[$], wr_val[$], pc_wr[$];

  always @(posedge clk) begin
    #1;
    if (o_done) done_cnt++;
    if (o_busy) busy_cnt++;
    if (o_rd_wr_en) begin wr_idx.push_back(32'(o_addr_rd)); wr_val.push_back(o_rd); end
    if (o_pc_wr_en) pc_wr.push_back(o_pc_val);
    if (o_rd_wr_en && o_pc_wr_en) proto_err++;
  end

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] any_out();
    return 32'(|{o_busy, o_done, o_addr_rt, o_addr_rd, o_rd, o_rd_wr_en, o_pc_wr_en, o_pc_val,
                 mem_bus.o_mem_req, mem_bus.o_mem_we, mem_bus.o_mem_addr, mem_bus.o_mem_wdata});
  endfunction

  task automatic start_op(input logic ld, input logic [15:0] list, input logic [31:0] base,
                          input logic [3:0] breg, input logic inc, input logic bef, input logic wb);
    @(negedge clk);
    st_addr.delete(); st_data.delete(); ld_addr.delete();
    wr_idx.delete(); wr_val.delete(); pc_wr.delete();
    done0 = done_cnt; busy0 = busy_cnt;
    i_load = ld; i_reg_list = list; i_base = base; i_base_reg = breg;
    i_incr = inc; i_before = bef; i_wback = wb; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (o_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, 32'(o_done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_stm_ia(input string tag);
    chk({tag, "_st_n"},   32'(st_addr.size()), 32'd2);
    chk({tag, "_st_a0"},  at(st_addr, 0), 32'h0000_1000);
    chk({tag, "_st_d0"},  at(st_data, 0), 32'hC0DE_0001);
    chk({tag, "_st_a1"},  at(st_addr, 1), 32'h0000_1004);
    chk({tag, "_st_d1"},  at(st_data, 1), 32'hC0DE_0003);
    chk({tag, "_wr_n"},   32'(wr_idx.size()), 32'd1);
    chk({tag, "_wb_idx"}, at(wr_idx, 0), 32'd13);
    chk({tag, "_wb_val"}, at(wr_val, 0), 32'h0000_1008);
    chk({tag, "_busy"},   32'(busy_cnt - busy0), 32'd7);
    chk({tag, "_done_n"}, 32'(done_cnt - done0), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; i_start = 1'b0; i_load = 1'b0; i_reg_list = '0; i_base = '0;
    i_base_reg = '0; i_incr = 1'b0; i_before = 1'b0; i_wback = 1'b0;
    mem_bus.i_mem_gnt = 1'b0; mem_bus.i_mem_rvalid = 1'b0; mem_bus.i_mem_rdata = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", any_out(), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(o_busy), 32'd0);

    // STM IA, r1/r3, writeback to r13.
    start_op(1'b0, 16'h000A, 32'h0000_1000, 4'd13, 1'b1, 1'b0, 1'b1);
    wait_done("stm_ia");
    check_stm_ia("stm_ia");

    // LDM DB, r0/r1/r15, writeback to r13.
    start_op(1'b1, 16'h8003, 32'h0000_2000, 4'd13, 1'b0, 1'b1, 1'b1);
    wait_done("ldm_db");
    chk("ldm_db_ld_n",  32'(ld_addr.size()), 32'd3);
    chk("ldm_db_a0",    at(ld_addr, 0), 32'h0000_1FF4);
    chk("ldm_db_a1",    at(ld_addr, 1), 32'h0000_1FF8);
    chk("ldm_db_a2",    at(ld_addr, 2), 32'h0000_1FFC);
    chk("ldm_db_wr_n",  32'(wr_idx.size()), 32'd3);
    chk("ldm_db_r0",    at(wr_val, 0), 32'h5A5A_1FF7);
    chk("ldm_db_r1_i",  at(wr_idx, 1), 32'd1);
    chk("ldm_db_r1",    at(wr_val, 1), 32'h5A5A_1FFB);
    chk("ldm_db_pc_n",  32'(pc_wr.size()), 32'd1);
    chk("ldm_db_pc",    at(pc_wr, 0), 32'h5A5A_1FFC);
    chk("ldm_db_wb_i",  at(wr_idx, 2), 32'd13);
    chk("ldm_db_wb",    at(wr_val, 2), 32'h0000_1FF4);
    chk("ldm_db_busy",  32'(busy_cnt - busy0), 32'd12);

    // Load with the base register in the list: loaded value, no writeback.
    start_op(1'b1, 16'h0004, 32'h0000_3000, 4'd2, 1'b1, 1'b0, 1'b1);
    wait_done("ld_base");
    chk("ld_base_a",    at(ld_addr, 0), 32'h0000_3000);
    chk("ld_base_wr_n", 32'(wr_idx.size()), 32'd1);
    chk("ld_base_idx",  at(wr_idx, 0), 32'd2);
    chk("ld_base_val",  at(wr_val, 0), 32'h5A5A_3003);

    // Empty list: CALC and DONE only.
    start_op(1'b0, 16'h0000, 32'h0000_7000, 4'd4, 1'b1, 1'b0, 1'b1);
    wait_done("empty");
    chk("empty_busy",   32'(busy_cnt - busy0), 32'd2);
    chk("empty_req",    32'(st_addr.size() + ld_addr.size()), 32'd0);
    chk("empty_wr",     32'(wr_idx.size() + pc_wr.size()), 32'd0);

    // Stalled LDM IB, with start pulses while busy.
    gnt_delay = 5; rvalid_delay = 3;
    start_op(1'b1, 16'h0030, 32'h0000_4000, 4'd7, 1'b1, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk); i_start = 1'b1; i_reg_list = 16'hFFFF;
      @(negedge clk); i_start = 1'b0;
    end
    wait_done("stall_ld");
    chk("stall_ld_n",    32'(ld_addr.size()), 32'd2);
    chk("stall_ld_a0",   at(ld_addr, 0), 32'h0000_4004);
    chk("stall_ld_a1",   at(ld_addr, 1), 32'h0000_4008);
    chk("stall_ld_wr_n", 32'(wr_idx.size()), 32'd2);
    chk("stall_ld_r4",   at(wr_val, 0), 32'h5A5A_4007);
    chk("stall_ld_r5",   at(wr_val, 1), 32'h5A5A_400B);
    chk("stall_ld_dn",   32'(done_cnt - done0), 32'd1);

    // Stalled STM DA, r0/r6, writeback to r9.
    start_op(1'b0, 16'h0041, 32'h0000_5000, 4'd9, 1'b0, 1'b0, 1'b1);
    wait_done("stall_st");
    chk("stall_st_a0",   at(st_addr, 0), 32'h0000_4FFC);
    chk("stall_st_d0",   at(st_data, 0), 32'hC0DE_0000);
    chk("stall_st_a1",   at(st_addr, 1), 32'h0000_5000);
    chk("stall_st_d1",   at(st_data, 1), 32'hC0DE_0006);
    chk("stall_st_wb",   at(wr_val, 0), 32'h0000_4FF8);
    chk("stall_stable",  32'(stable_err), 32'd0);

    // Async reset while waiting for load data.
    gnt_delay = 0; rvalid_delay = 10;
    start_op(1'b1, 16'h0003, 32'h0000_6000, 4'd5, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (ld_addr.size() == 0 && n < 20) begin @(negedge clk); n++; end
    chk("rst_first_req", 32'(ld_addr.size()), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_async_outs", any_out(), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_wr",   32'(wr_idx.size() + pc_wr.size()), 32'd0);
    chk("rst_no_req",  32'(ld_addr.size() + st_addr.size()), 32'd1);
    chk("rst_no_done", 32'(done_cnt - done0), 32'd0);

    rvalid_delay = 0;
    start_op(1'b0, 16'h000A, 32'h0000_1000, 4'd13, 1'b1, 1'b0, 1'b1);
    wait_done("post_rst");
    check_stm_ia("post_rst");

    chk("protocol", 32'(proto_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
